// File: rtl/free_list_pkg.sv
`default_nettype none
// ============================================================================
//  free_list_pkg
//  Shared types and constants for the rename-stage physical-register free list.
//  Revision: 1.0
// ============================================================================
package free_list_pkg;

  localparam int NUM_PR   = 64;
  localparam int NUM_ARCH = 32;
  localparam int NUM_ROB  = 8;
  localparam int FL_SIZE  = NUM_PR - NUM_ARCH;

  localparam int PR_W     = $clog2(NUM_PR);
  localparam int ROB_W    = $clog2(NUM_ROB);
  localparam int FL_IDX_W = $clog2(FL_SIZE);
  localparam int PTR_W    = FL_IDX_W + 1;
  localparam int CNT_W    = $clog2(FL_SIZE) + 1;

  typedef struct packed {
    logic [PR_W-1:0] T_idx;
  } FL_MAP_TABLE_OUT_t;

  typedef struct packed {
    logic [PR_W-1:0] Told_idx;
  } ROB_FL_OUT_t;

  // MSB is the wrap bit that tells full apart from empty.
  typedef struct packed {
    logic                wrap;
    logic [FL_IDX_W-1:0] idx;
  } FL_PTR_t;

  localparam FL_PTR_t FL_RESET_HEAD = '{wrap: 1'b0, idx: '0};
  localparam FL_PTR_t FL_RESET_TAIL = '{wrap: 1'b1, idx: '0};

  function automatic FL_PTR_t ptr_inc(input FL_PTR_t p);
    logic [PTR_W-1:0] v;
    v = p + PTR_W'(1);
    return FL_PTR_t'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
//  free_list
//  Circular FIFO of free physical registers with per-ROB-entry head checkpoints.
//  Revision: 1.0
// ============================================================================
module free_list
  import free_list_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 dispatch_en,
  input  logic                 retire_en,
  input  logic [PR_W-1:0]      retire_Told_idx,
  input  logic                 rollback_en,
  input  logic [ROB_W-1:0]     ROB_idx,
  input  logic [ROB_W-1:0]     ROB_rollback_idx,
  output FL_MAP_TABLE_OUT_t    FL_Map_Table_out,
  output logic                 FL_valid,
  output logic [CNT_W-1:0]     FL_count
);

  logic [PR_W-1:0] r_fl [FL_SIZE];
  FL_PTR_t         r_head;
  FL_PTR_t         r_tail;
  FL_PTR_t         r_backup [NUM_ROB];

  logic [PR_W-1:0] w_fl_next [FL_SIZE];
  FL_PTR_t         w_head_next;
  FL_PTR_t         w_tail_next;
  FL_PTR_t         w_backup_next [NUM_ROB];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head.idx == r_tail.idx) && (r_head.wrap != r_tail.wrap);

  // A rollback squashes any same-cycle dispatch; a retire is older and still lands.
  assign w_pop  = en && dispatch_en && !w_empty && !rollback_en;
  assign w_push = en && retire_en;

  assign FL_Map_Table_out.T_idx = r_fl[r_head.idx];
  assign FL_valid               = !w_empty;
  assign FL_count               = CNT_W'(r_tail - r_head);

  always_comb begin
    w_fl_next   = r_fl;
    w_head_next = r_head;
    w_tail_next = r_tail;
    if (en && rollback_en) begin
      w_head_next = r_backup[ROB_rollback_idx];
    end else if (w_pop) begin
      w_head_next = ptr_inc(r_head);
    end
    if (w_push) begin
      w_fl_next[r_tail.idx] = retire_Told_idx;
      w_tail_next           = ptr_inc(r_tail);
    end
  end

  // Checkpoint the post-pop head so it lines up with the map-table snapshot.
  always_comb begin
    w_backup_next = r_backup;
    if (w_pop) begin
      w_backup_next[ROB_idx] = ptr_inc(r_head);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        r_fl[i] <= PR_W'(NUM_ARCH + i);
      end
      for (int j = 0; j < NUM_ROB; j++) begin
        r_backup[j] <= FL_RESET_HEAD;
      end
      r_head <= FL_RESET_HEAD;
      r_tail <= FL_RESET_TAIL;
    end else if (en) begin
      r_fl     <= w_fl_next;
      r_backup <= w_backup_next;
      r_head   <= w_head_next;
      r_tail   <= w_tail_next;
    end
  end

  property p_no_overfill;
    @(posedge clock) disable iff (!reset)
      (en && retire_en && !w_pop) |-> !w_full;
  endproperty
  a_no_overfill: assert property (p_no_overfill)
    else $error("free list overfilled by retire push");

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
//  tb_free_list
//  Directed, table-driven checks of the free list plus multi-cycle sequences.
//  Revision: 1.0
// ============================================================================
module tb_free_list;
  import free_list_pkg::*;

  logic              clock;
  logic              reset;
  logic              en;
  logic              dispatch_en;
  logic              retire_en;
  logic [PR_W-1:0]   retire_Told_idx;
  logic              rollback_en;
  logic [ROB_W-1:0]  ROB_idx;
  logic [ROB_W-1:0]  ROB_rollback_idx;
  FL_MAP_TABLE_OUT_t FL_Map_Table_out;
  logic              FL_valid;
  logic [CNT_W-1:0]  FL_count;

  int checks;
  int failures;

  free_list dut (
    .clock            (clock),
    .reset            (reset),
    .en               (en),
    .dispatch_en      (dispatch_en),
    .retire_en        (retire_en),
    .retire_Told_idx  (retire_Told_idx),
    .rollback_en      (rollback_en),
    .ROB_idx          (ROB_idx),
    .ROB_rollback_idx (ROB_rollback_idx),
    .FL_Map_Table_out (FL_Map_Table_out),
    .FL_valid         (FL_valid),
    .FL_count         (FL_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic en;
    logic disp;
    logic ret;
    int   told;
    logic rb;
    int   rob;
    int   rbi;
    int   exp_t;
    int   exp_v;
    int   exp_c;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int t, input int v, input int c);
    check({tag, ".T_idx"}, int'(FL_Map_Table_out.T_idx), t);
    check({tag, ".valid"}, int'(FL_valid), v);
    check({tag, ".count"}, int'(FL_count), c);
  endtask

  task automatic drive(input logic e, input logic d, input logic r, input int told,
                       input logic rb, input int rob, input int rbi);
    en               = e;
    dispatch_en      = d;
    retire_en        = r;
    retire_Told_idx  = PR_W'(told);
    rollback_en      = rb;
    ROB_idx          = ROB_W'(rob);
    ROB_rollback_idx = ROB_W'(rbi);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  initial begin
    int q[$];
    int exp_t;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    #12;
    reset = 1'b1;
    check_out("reset", 32, 1, 32);

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 0,  1'b0, 0, 0, 33, 1, 31};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 0,  1'b0, 1, 0, 34, 1, 30};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 0,  1'b0, 2, 0, 35, 1, 29};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 0,  1'b0, 3, 0, 36, 1, 28};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 0,  1'b0, 4, 0, 37, 1, 27};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 0,  1'b1, 0, 1, 34, 1, 30};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 0,  1'b1, 5, 2, 35, 1, 29};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 7,  1'b1, 0, 2, 35, 1, 30};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 9,  1'b0, 6, 0, 36, 1, 30};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 11, 1'b1, 0, 4, 36, 1, 30};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 31, 1'b0, 0, 0, 36, 1, 31};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 0,  1'b0, 0, 0, 36, 1, 31};

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].en, tbl[i].disp, tbl[i].ret, tbl[i].told,
            tbl[i].rb, tbl[i].rob, tbl[i].rbi);
      step();
      check_out($sformatf("vec%0d", i), tbl[i].exp_t, tbl[i].exp_v, tbl[i].exp_c);
    end

    // Drain to empty, poke dispatch while empty, then refill by one.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 32; i++) step();
    check("empty.valid", int'(FL_valid), 0);
    check("empty.count", int'(FL_count), 0);
    step();
    step();
    check("empty_disp.valid", int'(FL_valid), 0);
    check("empty_disp.count", int'(FL_count), 0);
    drive(1'b1, 1'b0, 1'b1, 5, 1'b0, 0, 0);
    step();
    check_out("refill", 5, 1, 1);

    // Simultaneous pop+push across pointer wrap, tracked with a queue model.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    step();
    q.delete();
    for (int i = 33; i < 64; i++) q.push_back(i);
    check_out("wrap_start", q[0], 1, 31);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i * 7) % 64, 1'b0, i % 8, 0);
      step();
      void'(q.pop_front());
      q.push_back((i * 7) % 64);
      exp_t = q[0];
      check($sformatf("wrap%0d.T_idx", i), int'(FL_Map_Table_out.T_idx), exp_t);
      check($sformatf("wrap%0d.count", i), int'(FL_count), 31);
    end

    // Checkpoints cleared by reset, then async reset during dispatch streaming.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    step();
    step();
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 0, 7);
    step();
    check_out("rb_reset_ckpt", 32, 1, 32);
    drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 3, 0);
    step();
    step();
    step();
    check_out("stream", 35, 1, 29);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_out("async_reset", 32, 1, 32);
    dispatch_en = 1'b0;
    #1;
    reset = 1'b1;

    // Global hold: en low freezes everything despite dispatch requests.
    drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    step();
    step();
    step();
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("hold%0d", i), 35, 1, 29);
    end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
